mac_seq_ctrl: RTL and testbench

MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

---
 rtl/mac_pkg.sv | 41 ++++
 rtl/mac_mul.sv | 76 +++++++
 rtl/mac_seq_ctrl.sv | 129 ++++++++++++
 tb/tb_mac_seq_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the dot-product MAC sequencer: default widths,
// controller state encoding and the 5:2 compressor cell.
package mac_pkg;

    localparam int DW_DEF   = 8;
    localparam int ACCW_DEF = 24;
    localparam int LENW_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One bit-slice of a 5:2 compressor: sum has the column weight; carry,
    // co1 and co2 all carry twice that weight. co1/co2 feed the next column
    // as ci1/ci2 and do not depend on the incoming ci, so nothing ripples.
    typedef struct packed {
        logic sum;
        logic carry;
        logic co1;
        logic co2;
    } c52_t;

    function automatic c52_t cmp52(input logic x1, input logic x2, input logic x3,
                                   input logic x4, input logic x5,
                                   input logic ci1, input logic ci2);
        c52_t r;
        logic s1;
        logic s2;
        s1      = x1 ^ x2 ^ x3;
        r.co1   = (x1 & x2) | (x1 & x3) | (x2 & x3);
        s2      = s1 ^ x4 ^ x5;
        r.co2   = (s1 & x4) | (s1 & x5) | (x4 & x5);
        r.sum   = s2 ^ ci1 ^ ci2;
        r.carry = (s2 & ci1) | (s2 & ci2) | (ci1 & ci2);
        return r;
    endfunction

endpackage

// File: rtl/mac_mul.sv
// Combinational unsigned DW x DW multiplier. Partial products are reduced
// in carry-save form with rows of 5:2 compressor cells (five words in, two
// words out per group) until two words remain, then one carry-propagate add.
module mac_mul
    import mac_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW-1:0]   i_a,
    input  logic [DW-1:0]   i_b,
    output logic [2*DW-1:0] o_p
);

    localparam int PW     = 2 * DW;
    localparam int NG     = (DW + 4) / 5;  // compressor groups per round
    localparam int NW     = 5 * NG;        // word slots, padded to whole groups
    localparam int ROUNDS = DW;            // generous bound; extra rounds keep two words

    // Partial-product generation followed by the compressor tree and final adder.
    always_comb begin : reduce
        logic [PW-1:0] w   [NW];
        logic [PW-1:0] nw  [NW];
        logic [PW-1:0] x   [5];
        logic [PW-1:0] cv;
        c52_t          c;
        logic          ci1;
        logic          ci2;

        for (int j = 0; j < NW; j++) begin
            w[j]  = '0;
            nw[j] = '0;
        end
        for (int k = 0; k < 5; k++) begin
            x[k] = '0;
        end
        cv  = '0;
        c   = '0;
        ci1 = 1'b0;
        ci2 = 1'b0;

        for (int j = 0; j < DW; j++) begin
            if (i_b[j]) begin
                w[j] = PW'(i_a) << j;
            end
        end

        for (int r = 0; r < ROUNDS; r++) begin
            for (int j = 0; j < NW; j++) begin
                nw[j] = '0;
            end
            for (int g = 0; g < NG; g++) begin
                for (int k = 0; k < 5; k++) begin
                    x[k] = w[5*g + k];
                end
                ci1 = 1'b0;
                ci2 = 1'b0;
                cv  = '0;
                for (int i = 0; i < PW; i++) begin
                    c = cmp52(x[0][i], x[1][i], x[2][i], x[3][i], x[4][i], ci1, ci2);
                    nw[2*g][i] = c.sum;
                    cv[i]      = c.carry;
                    ci1        = c.co1;
                    ci2        = c.co2;
                end
                // Carries out of the top column fall off: the true product fits in PW bits.
                nw[2*g + 1] = cv << 1;
            end
            for (int j = 0; j < NW; j++) begin
                w[j] = nw[j];
            end
        end

        o_p = w[0] + w[1];
    end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: accepts cfg_len operand pairs, multiplies each pair
// through mac_mul, accumulates the products and presents the sum until the
// consumer takes it. The product is registered one cycle ahead of the add.
module mac_seq_ctrl
    import mac_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int ACCW = ACCW_DEF,
    parameter int LENW = LENW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [LENW-1:0] cfg_len,
    output logic            busy,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_a,
    input  logic [DW-1:0]   in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ACCW-1:0] out_acc,
    output logic            out_ovf
);

    state_t            r_state;
    state_t            w_next;
    logic [LENW-1:0]   r_len;
    logic [LENW-1:0]   r_cnt;
    logic [2*DW-1:0]   r_prod;
    logic              r_prod_vld;
    logic [ACCW-1:0]   r_acc;
    logic              r_ovf;

    logic [2*DW-1:0]   w_prod;
    logic              w_hs;
    logic              w_start;
    logic              w_last;
    logic              w_carry;
    logic [ACCW-1:0]   w_sum;

    mac_mul #(.DW(DW)) u_mul (
        .i_a (in_a),
        .i_b (in_b),
        .o_p (w_prod)
    );

    assign w_hs    = in_valid && (r_state == ST_RUN);
    assign w_start = start && (r_state == ST_IDLE);
    assign w_last  = w_hs && (LENW'(r_cnt + 1'b1) == r_len);
    assign {w_carry, w_sum} = {1'b0, r_acc} + (ACCW + 1)'(r_prod);

    assign out_acc = r_acc;
    assign out_ovf = r_ovf;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and handshake/status outputs.
    always_comb begin
        w_next    = r_state;
        busy      = 1'b1;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = (cfg_len != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                in_ready = 1'b1;
                if (w_last) begin
                    w_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                w_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Job setup, product capture, pair counting and accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len      <= '0;
            r_cnt      <= '0;
            r_prod     <= '0;
            r_prod_vld <= 1'b0;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
        end else if (w_start) begin
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_prod_vld <= 1'b0;
            if (cfg_len != '0) begin
                r_len <= cfg_len;
                r_cnt <= '0;
            end
        end else begin
            r_prod_vld <= w_hs;
            if (w_hs) begin
                r_prod <= w_prod;
                r_cnt  <= r_cnt + 1'b1;
            end
            if (r_prod_vld) begin
                r_acc <= w_sum;
                r_ovf <= r_ovf | w_carry;
            end
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: two instances (24-bit and 16-bit accumulators)
// share one stimulus stream; a job-level model predicts status and result.
module tb_mac_seq_ctrl;

    localparam int DW   = 8;
    localparam int LENW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            start = 1'b0;
    logic [LENW-1:0] cfg_len = '0;
    logic            in_valid = 1'b0;
    logic [DW-1:0]   in_a = '0;
    logic [DW-1:0]   in_b = '0;
    logic            out_ready = 1'b1;

    logic            busy_w, ready_w, valid_w, ovf_w;
    logic [23:0]     acc_w;
    logic            busy_n, ready_n, valid_n, ovf_n;
    logic [15:0]     acc_n;

    int n_chk  = 0;
    int n_pass = 0;

    mac_seq_ctrl #(.DW(DW), .ACCW(24), .LENW(LENW)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .busy(busy_w),
        .in_valid(in_valid), .in_ready(ready_w), .in_a(in_a), .in_b(in_b),
        .out_valid(valid_w), .out_ready(out_ready), .out_acc(acc_w), .out_ovf(ovf_w)
    );

    mac_seq_ctrl #(.DW(DW), .ACCW(16), .LENW(LENW)) dut_n (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .busy(busy_n),
        .in_valid(in_valid), .in_ready(ready_n), .in_a(in_a), .in_b(in_b),
        .out_valid(valid_n), .out_ready(out_ready), .out_acc(acc_n), .out_ovf(ovf_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // Job-level model: idle / accepting (pairs left) / one-cycle drain / result held.
    bit     m_idle  = 1'b1;
    bit     m_flush = 1'b0;
    bit     m_valid = 1'b0;
    int     m_left  = 0;
    longint m_sum   = 0;

    function automatic longint exp_acc(input int w);
        return m_sum & ((longint'(1) << w) - 1);
    endfunction

    function automatic longint exp_ovf(input int w);
        return ((m_sum >> w) != 0) ? 1 : 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idle = 1'b1; m_flush = 1'b0; m_valid = 1'b0; m_left = 0; m_sum = 0;
        end else if (m_idle) begin
            if (start) begin
                m_idle = 1'b0;
                m_sum  = 0;
                m_left = int'(cfg_len);
                if (cfg_len == 0) m_valid = 1'b1;
            end
        end else if (m_left > 0) begin
            if (in_valid) begin
                m_sum  = m_sum + longint'(in_a) * longint'(in_b);
                m_left = m_left - 1;
                if (m_left == 0) m_flush = 1'b1;
            end
        end else if (m_flush) begin
            m_flush = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
            m_idle  = 1'b1;
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        chk("busy24",  busy_w,  !m_idle);
        chk("busy16",  busy_n,  !m_idle);
        chk("ready24", ready_w, (!m_idle && m_left > 0));
        chk("ready16", ready_n, (!m_idle && m_left > 0));
        chk("valid24", valid_w, m_valid);
        chk("valid16", valid_n, m_valid);
        if (m_valid) begin
            chk("acc24", acc_w, exp_acc(24));
            chk("ovf24", ovf_w, exp_ovf(24));
            chk("acc16", acc_n, exp_acc(16));
            chk("ovf16", ovf_n, exp_ovf(16));
        end
        if (!rst_n) begin
            chk("rst_acc24", acc_w, 0);
            chk("rst_ovf16", ovf_n, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int len);
        start   = 1'b1;
        cfg_len = LENW'(len);
        tick();
        start   = 1'b0;
        cfg_len = 8'hA5;
    endtask

    task automatic send(input int a, input int b, input int gap);
        in_a     = DW'(a);
        in_b     = DW'(b);
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !ready_w; i++) tick();
        chk("ready_wait", ready_w, 1);
        tick();
        in_valid = 1'b0;
        in_a     = DW'($urandom);
        in_b     = DW'($urandom);
        for (int i = 0; i < gap; i++) tick();
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20 && !valid_w; i++) tick();
        chk("valid_timeout", valid_w, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy_w, 0);
        chk("rst_valid", valid_w, 0);
        chk("rst_acc", acc_w, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // in_valid while idle must be ignored
        in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9;
        repeat (2) tick();
        in_valid = 1'b0;
        tick();

        // Three pairs back to back, result two cycles after last handshake
        do_start(3);
        send(2, 3, 0);
        send(4, 5, 0);
        send(255, 255, 0);
        chk("lat_T1_valid", valid_w, 0);
        tick();
        chk("lat_T2_valid", valid_w, 1);
        chk("job1_acc", acc_w, 65051);
        chk("job1_ovf", ovf_w, 0);
        tick();
        chk("job1_idle", busy_w, 0);

        // Zero-length job
        do_start(0);
        chk("len0_valid", valid_w, 1);
        chk("len0_acc", acc_w, 0);
        chk("len0_ready", ready_w, 0);
        tick();

        // Overflow on the 16-bit instance, then cleared by the next job
        do_start(2);
        send(255, 255, 0);
        send(255, 255, 0);
        wait_valid();
        chk("ovf_acc16", acc_n, 64514);
        chk("ovf_flag16", ovf_n, 1);
        chk("ovf_acc24", acc_w, 130050);
        tick();
        do_start(1);
        send(1, 1, 0);
        wait_valid();
        chk("clr_acc16", acc_n, 1);
        chk("clr_ovf16", ovf_n, 0);
        tick();

        // Gapped input and a held-off consumer
        out_ready = 1'b0;
        do_start(4);
        send(10, 20, 1);
        send(30, 40, 3);
        send(50, 60, 2);
        send(70, 80, 0);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", valid_w, 1);
            chk("hold_acc", acc_w, 10000);
            chk("hold_ovf", ovf_w, 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("hold_idle", busy_w, 0);

        // start pulses during RUN and DONE are ignored
        out_ready = 1'b0;
        do_start(3);
        send(1, 2, 0);
        start = 1'b1; cfg_len = 8'd7;
        send(3, 4, 0);
        start = 1'b0;
        send(5, 6, 0);
        wait_valid();
        start = 1'b1;
        repeat (2) tick();
        chk("ign_acc", acc_w, 44);
        chk("ign_valid", valid_w, 1);
        start = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("ign_idle", busy_w, 0);

        // Reset mid-job aborts it asynchronously
        do_start(5);
        send(1, 1, 0);
        send(2, 2, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy_w, 0);
        chk("abort_ready", ready_w, 0);
        chk("abort_valid", valid_w, 0);
        chk("abort_acc24", acc_w, 0);
        chk("abort_acc16", acc_n, 0);
        chk("abort_ovf", ovf_w, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", busy_w, 0);
        do_start(1);
        send(7, 9, 0);
        wait_valid();
        chk("post_rst_acc", acc_w, 63);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
